viterbi_decoder_k3: RTL
=======================

Name: viterbi_decoder_k3

Overview:
- Hard-decision Viterbi decoder for the team's rate-1/2, constraint-length-3 convolutional code.
- Sits directly downstream of the encoder (after the channel) and recovers the original bit stream from (c0, c1) symbol pairs.
- Code definition, with u_k the newest input bit: c0 = u_k ^ u_{k-2}, c1 = u_k ^ u_{k-1} ^ u_{k-2}. Encoder starts in the all-zero state.
- Survivors are kept by register exchange, so there is no traceback FSM.

Parameters:
- TB_DEPTH, 16, survivor length in symbols; also the decode latency in symbols; legal range 4..64.
- PM_W, 4, path-metric width in bits; minimum 4.

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high; clock clk
- clear  input  1  synchronous frame restart; same effect as reset, takes priority over in_valid
- in_valid  input  1  symbol present this cycle
- in_c0  input  1  received first code bit
- in_c1  input  1  received second code bit
- out_valid  output  1  one-cycle pulse: out_bit is valid
- out_bit  output  1  decoded bit
- best_metric_zero  output  1  high when the symbol just accepted matched the best path exactly (branch metric 0 on the winning transition)

Behaviour:
- State index s = {u_{k-1}, u_{k-2}}, MSB newest. With input u, the next state is {u, u_{k-1}}.
- Predecessors of next state {a,b}: {b,0} and {b,1}. Expected symbol on each branch follows the code equations above.
- Branch metric is Hamming distance 0..2 between (in_c0, in_c1) and the expected pair.
- ACS, per next state:
  - candidate = PM[pred] + BM.
  - Pick the smaller candidate; on a tie pick the predecessor with LSB 0.
  - Decision bit u = MSB of the next state.
- Normalisation: in the same cycle, subtract the minimum of the four new metrics from all four. The stored best metric is always 0.
  - best state = lowest-index state with metric 0.
  - Max stored metric stays below 2^PM_W; no overflow or saturation logic is needed.
- Survivors: SURV[ns] <= {SURV[pred][TB_DEPTH-2:0], u}, one TB_DEPTH-bit register per state.
- Updates happen only on a clock edge where in_valid=1. When in_valid=0, all state holds and out_valid=0.
- Fill counter: counts accepted symbols and saturates at TB_DEPTH-1.
- Output timing, for an accepted symbol with index k (first symbol after reset/clear is k=0):
  - If k >= TB_DEPTH-1, then on the same edge: out_valid<=1, out_bit <= bit TB_DEPTH-1 (oldest) of the newly computed survivor of the best state.
  - This bit is the estimate of u_{k-TB_DEPTH+1}. Latency is exactly TB_DEPTH-1 accepted symbols plus a registered output.
  - Otherwise out_valid<=0.
- Reset and clear values:
  - PM[0]=0, PM[1..3]=3.
  - All survivors 0, fill counter 0.
  - out_valid=0, out_bit=0, best_metric_zero=0.
- Reset or clear mid-frame discards all history. The next accepted symbol is k=0 again.
- clear together with in_valid: clear wins and the symbol is dropped.
- No backpressure: the block accepts one symbol per cycle at full rate.
- Bits still in flight at end of frame are flushed by the upstream sending TB_DEPTH-1 tail symbols (encoder fed zeros).

Optional Feature:
- Macro VITERBI_ERASURE_EN.
- When defined:
  - Adds input port in_erase, 2 bits: bit0 marks c0 erased, bit1 marks c1 erased.
  - An erased bit contributes 0 to the branch metric on every branch.
  - Both bits erased gives BM=0 for all branches; metrics still normalise.
  - This supports punctured streams.
- When undefined: the port is absent and both bits always count.

Test Plan:
- Reset, then 20 symbols of 00 with in_valid=1 every cycle -> out_valid first high on the edge accepting symbol 15 (TB_DEPTH=16); 5 pulses total; out_bit=0 on all.
- Encoded message 1,0,1,1,0,0,0 plus 15 zero tail bits. Symbols (c0c1): 11,01,00,10,10,11,00, then 00 x15 -> first 7 out_bits 1,0,1,1,0,0,0.
- Same stream with symbol 3 corrupted from 10 to 00 (single bit error) -> identical decoded output; best_metric_zero=0 on that symbol's edge.
- Same stream with in_valid dropped for 3 cycles between symbols 2 and 3 -> no out_valid during gaps; decoded sequence unchanged.
- Assert clear after symbol 10, then replay the message stream -> first out_valid again 15 accepted symbols after clear; output matches the message; no stale bits appear.
- (VITERBI_ERASURE_EN) Message stream with in_erase=2'b01 on symbols 1 and 4 -> decoded output 1,0,1,1,0,0,0.

Source files
------------

// File: rtl/viterbi_decoder_k3.sv
// Hard-decision register-exchange Viterbi decoder for the rate-1/2, K=3 code (c0 = u^u2, c1 = u^u1^u2).
// Optional erasure input (punctured streams) is enabled by defining VITERBI_ERASURE_EN.
module viterbi_decoder_k3 #(
    parameter int TB_DEPTH = 16,
    parameter int PM_W     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       in_valid,
    input  logic       in_c0,
    input  logic       in_c1,
`ifdef VITERBI_ERASURE_EN
    input  logic [1:0] in_erase,
`endif
    output logic       out_valid,
    output logic       out_bit,
    output logic       best_metric_zero
);

    localparam int CW = PM_W + 1;
    localparam int FILL_W = $clog2(TB_DEPTH);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TB_DEPTH - 1);

    logic [PM_W-1:0]     pathMetric [4];
    logic [TB_DEPTH-1:0] survivor   [4];
    logic [FILL_W-1:0]   fillCount;

    logic [1:0]          eraseMask;
    logic [1:0]          bmLo       [4];
    logic [1:0]          bmHi       [4];
    logic [CW-1:0]       candLo     [4];
    logic [CW-1:0]       candHi     [4];
    logic [CW-1:0]       rawMetric  [4];
    logic [1:0]          winPred    [4];
    logic [1:0]          winBm      [4];
    logic [PM_W-1:0]     newMetric  [4];
    logic [TB_DEPTH-1:0] newSurv    [4];
    logic [CW-1:0]       minMetric;
    logic [1:0]          bestState;

    // Hamming distance between the received pair and the pair expected on one branch.
    function automatic logic [1:0] branchMetric(input logic [1:0] pred, input logic u,
                                                input logic c0, input logic c1,
                                                input logic [1:0] erase);
        logic d0;
        logic d1;
        d0 = ((u ^ pred[0]) ^ c0) & ~erase[0];
        d1 = ((u ^ pred[1] ^ pred[0]) ^ c1) & ~erase[1];
        return {1'b0, d0} + {1'b0, d1};
    endfunction

`ifdef VITERBI_ERASURE_EN
    assign eraseMask = in_erase;
`else
    assign eraseMask = 2'b00;
`endif

    // Add-compare-select for every next state, then normalise against the smallest new metric.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bmLo[i]   = branchMetric({i[0], 1'b0}, i[1], in_c0, in_c1, eraseMask);
            bmHi[i]   = branchMetric({i[0], 1'b1}, i[1], in_c0, in_c1, eraseMask);
            candLo[i] = CW'(pathMetric[{i[0], 1'b0}]) + CW'(bmLo[i]);
            candHi[i] = CW'(pathMetric[{i[0], 1'b1}]) + CW'(bmHi[i]);
            if (candHi[i] < candLo[i]) begin
                winPred[i]   = {i[0], 1'b1};
                rawMetric[i] = candHi[i];
                winBm[i]     = bmHi[i];
            end else begin
                winPred[i]   = {i[0], 1'b0};
                rawMetric[i] = candLo[i];
                winBm[i]     = bmLo[i];
            end
            newSurv[i] = (survivor[winPred[i]] << 1) | {{(TB_DEPTH-1){1'b0}}, i[1]};
        end
        minMetric = rawMetric[0];
        for (int i = 1; i < 4; i++) begin
            if (rawMetric[i] < minMetric) minMetric = rawMetric[i];
        end
        bestState = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rawMetric[i] == minMetric) bestState = 2'(i);
        end
        for (int i = 0; i < 4; i++) begin
            newMetric[i] = PM_W'(rawMetric[i] - minMetric);
        end
    end

    // State update only on accepted symbols; clear behaves exactly like reset and wins over in_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                pathMetric[i] <= (i == 0) ? PM_W'(0) : PM_W'(3);
                survivor[i]   <= '0;
            end
            fillCount        <= '0;
            out_valid        <= 1'b0;
            out_bit          <= 1'b0;
            best_metric_zero <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < 4; i++) begin
                pathMetric[i] <= (i == 0) ? PM_W'(0) : PM_W'(3);
                survivor[i]   <= '0;
            end
            fillCount        <= '0;
            out_valid        <= 1'b0;
            out_bit          <= 1'b0;
            best_metric_zero <= 1'b0;
        end else if (in_valid) begin
            for (int i = 0; i < 4; i++) begin
                pathMetric[i] <= newMetric[i];
                survivor[i]   <= newSurv[i];
            end
            best_metric_zero <= (winBm[bestState] == 2'd0);
            if (fillCount == FILL_MAX) begin
                out_valid <= 1'b1;
                out_bit   <= newSurv[bestState][TB_DEPTH-1];
            end else begin
                out_valid <= 1'b0;
                fillCount <= fillCount + 1'b1;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule
